// File: rtl/rf_pkg.sv
// Shared widths and the writeback request record used by the register-file
// write arbiter and its result queue.
package rf_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 32;

    localparam logic [ADDR_W-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/wb_kill_fifo.sv
// Circular queue of pending long-latency writebacks. Each entry carries a live
// bit that a newer pipeline write to the same register can clear in parallel.
module wb_kill_fifo
    import rf_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  wb_req_t                  push_req,
    input  logic                     pop,
    input  logic                     kill_en,
    input  logic [ADDR_W-1:0]        kill_addr,
    output wb_req_t                  head_req,
    output logic                     head_live,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);

    wb_req_t            mem_q [DEPTH];
    logic [DEPTH-1:0]   live_q, live_d;
    logic [DEPTH-1:0]   kill_hit;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]     count_q, count_d;

    // Match is evaluated on every slot; stale slots are harmless because a push
    // always re-arms the live bit of the slot it writes.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_kill
            assign kill_hit[gi] = kill_en && (mem_q[gi].addr == kill_addr);
        end
    endgenerate

    always_comb begin
        live_d   = live_q & ~kill_hit;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (push) begin
            live_d[wr_ptr_q] = 1'b1;
            wr_ptr_d         = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + (PTR_W+1)'(1);
            2'b01:   count_d = count_q - (PTR_W+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            live_q   <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            live_q   <= live_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload needs no reset: occupancy is tracked solely by the pointers and count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_req;
        end
    end

    assign head_req  = mem_q[rd_ptr_q];
    assign head_live = live_q[rd_ptr_q];
    assign empty     = (count_q == '0);
    assign full      = (count_q == (PTR_W+1)'(DEPTH));
    assign count     = count_q;

endmodule

// File: rtl/rf_write_arbiter.sv
// Single write port in front of the register file: pipeline writeback has strict
// priority, queued long-latency results fill idle slots, starvation raises a stall.
module rf_write_arbiter
    import rf_pkg::*;
#(
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        pipe_we,
    input  logic [ADDR_W-1:0]           pipe_addr,
    input  logic [DATA_W-1:0]           pipe_data,
    input  logic                        lu_valid,
    output logic                        lu_ready,
    input  logic [ADDR_W-1:0]           lu_addr,
    input  logic [DATA_W-1:0]           lu_data,
    output logic                        we3,
    output logic [ADDR_W-1:0]           a3,
    output logic [DATA_W-1:0]           wd3,
    output logic                        stall_req,
    output logic [$clog2(FIFO_DEPTH):0] q_count
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);

    wb_req_t            head_req;
    wb_req_t            push_req;
    logic               head_live;
    logic               q_empty;
    logic               q_full;
    logic               pipe_issue;
    logic               lu_push;
    logic               q_pop;

    logic               we3_q, we3_d;
    logic [ADDR_W-1:0]  a3_q, a3_d;
    logic [DATA_W-1:0]  wd3_q, wd3_d;
    logic               stall_req_q, stall_req_d;
    logic [SW-1:0]      starve_q, starve_d;

    assign pipe_issue = pipe_we && (pipe_addr != REG_ZERO);
    assign lu_push    = lu_valid && lu_ready && (lu_addr != REG_ZERO);
    assign q_pop      = !pipe_issue && !q_empty;
    assign push_req   = '{addr: lu_addr, data: lu_data};

    wb_kill_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (lu_push),
        .push_req  (push_req),
        .pop       (q_pop),
        .kill_en   (pipe_issue),
        .kill_addr (pipe_addr),
        .head_req  (head_req),
        .head_live (head_live),
        .empty     (q_empty),
        .full      (q_full),
        .count     (q_count)
    );

    always_comb begin
        we3_d = 1'b0;
        a3_d  = '0;
        wd3_d = '0;
        if (pipe_issue) begin
            we3_d = 1'b1;
            a3_d  = pipe_addr;
            wd3_d = pipe_data;
        end else if (q_pop && head_live) begin
            we3_d = 1'b1;
            a3_d  = head_req.addr;
            wd3_d = head_req.data;
        end
    end

    // Counter only advances while the head is blocked; any pop or an empty queue clears it.
    always_comb begin
        starve_d = starve_q;
        if (q_empty || q_pop) begin
            starve_d = '0;
        end else if (starve_q != SW'(STARVE_LIMIT)) begin
            starve_d = starve_q + SW'(1);
        end
        stall_req_d = (starve_d == SW'(STARVE_LIMIT));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we3_q       <= 1'b0;
            a3_q        <= '0;
            wd3_q       <= '0;
            stall_req_q <= 1'b0;
            starve_q    <= '0;
        end else begin
            we3_q       <= we3_d;
            a3_q        <= a3_d;
            wd3_q       <= wd3_d;
            stall_req_q <= stall_req_d;
            starve_q    <= starve_d;
        end
    end

    assign lu_ready  = !q_full;
    assign we3       = we3_q;
    assign a3        = a3_q;
    assign wd3       = wd3_q;
    assign stall_req = stall_req_q;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed checks of the register-file write arbiter: latency, priority, WAW kill,
// starvation stall, r0 handling and mid-operation reset.
module tb_rf_write_arbiter;
    import rf_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              pipe_we;
    logic [ADDR_W-1:0] pipe_addr;
    logic [DATA_W-1:0] pipe_data;
    logic              lu_valid;
    logic              lu_ready;
    logic [ADDR_W-1:0] lu_addr;
    logic [DATA_W-1:0] lu_data;
    logic              we3;
    logic [ADDR_W-1:0] a3;
    logic [DATA_W-1:0] wd3;
    logic              stall_req;
    logic [2:0]        q_count;

    int n_cmp = 0;
    int n_err = 0;

    rf_write_arbiter #(
        .FIFO_DEPTH   (4),
        .STARVE_LIMIT (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pipe_we   (pipe_we),
        .pipe_addr (pipe_addr),
        .pipe_data (pipe_data),
        .lu_valid  (lu_valid),
        .lu_ready  (lu_ready),
        .lu_addr   (lu_addr),
        .lu_data   (lu_data),
        .we3       (we3),
        .a3        (a3),
        .wd3       (wd3),
        .stall_req (stall_req),
        .q_count   (q_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end else begin
            $display("ok   %s = %0h", tag, obs);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pipe(input logic we, input logic [ADDR_W-1:0] ad, input logic [DATA_W-1:0] d);
        pipe_we   = we;
        pipe_addr = ad;
        pipe_data = d;
    endtask

    task automatic set_lu(input logic v, input logic [ADDR_W-1:0] ad, input logic [DATA_W-1:0] d);
        lu_valid = v;
        lu_addr  = ad;
        lu_data  = d;
    endtask

    task automatic check_wr(input string tag, input logic we, input logic [ADDR_W-1:0] ad,
                            input logic [DATA_W-1:0] d);
        check({tag, ".we3"}, 64'(we3), 64'(we));
        if (we) begin
            check({tag, ".a3"},  64'(a3),  64'(ad));
            check({tag, ".wd3"}, 64'(wd3), 64'(d));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        set_pipe(1'b0, '0, '0);
        set_lu(1'b0, '0, '0);
        step();
        step();
        rst_n = 1'b1;

        // Reset state
        check("rst.we3", 64'(we3), 64'd0);
        check("rst.a3", 64'(a3), 64'd0);
        check("rst.wd3", 64'(wd3), 64'd0);
        check("rst.stall", 64'(stall_req), 64'd0);
        check("rst.q_count", 64'(q_count), 64'd0);
        check("rst.lu_ready", 64'(lu_ready), 64'd1);

        // Single queued result: queued first cycle, written the next
        set_lu(1'b1, 5'd5, 32'hDEAD);
        step();
        set_lu(1'b0, '0, '0);
        check("t1.q_count", 64'(q_count), 64'd1);
        check_wr("t1.c1", 1'b0, '0, '0);
        step();
        check_wr("t1.c2", 1'b1, 5'd5, 32'hDEAD);
        check("t1.q_empty", 64'(q_count), 64'd0);

        // Pipeline beats queue in the same cycle
        set_pipe(1'b1, 5'd3, 32'h11);
        set_lu(1'b1, 5'd4, 32'h22);
        step();
        set_pipe(1'b0, '0, '0);
        set_lu(1'b0, '0, '0);
        check_wr("t2.c1", 1'b1, 5'd3, 32'h11);
        check("t2.q_count", 64'(q_count), 64'd1);
        step();
        check_wr("t2.c2", 1'b1, 5'd4, 32'h22);

        // WAW kill of an older queued entry
        set_lu(1'b1, 5'd7, 32'hAAAA);
        step();
        set_lu(1'b0, '0, '0);
        set_pipe(1'b1, 5'd7, 32'hBBBB);
        step();
        set_pipe(1'b0, '0, '0);
        check_wr("t3.pipe", 1'b1, 5'd7, 32'hBBBB);
        check("t3.q_held", 64'(q_count), 64'd1);
        step();
        check_wr("t3.silent_pop", 1'b0, '0, '0);
        check("t3.q_empty", 64'(q_count), 64'd0);

        // Entry pushed alongside a same-register pipe write is newer: not killed
        set_pipe(1'b1, 5'd6, 32'h66);
        set_lu(1'b1, 5'd6, 32'h77);
        step();
        set_pipe(1'b0, '0, '0);
        set_lu(1'b0, '0, '0);
        check_wr("t4.pipe", 1'b1, 5'd6, 32'h66);
        step();
        check_wr("t4.newer", 1'b1, 5'd6, 32'h77);

        // Fill the queue under continuous pipeline writes, then starve it
        set_pipe(1'b1, 5'd1, 32'h1);
        for (int i = 0; i < 4; i++) begin
            set_lu(1'b1, 5'(10 + i), 32'(32'h100 + 10 + i));
            step();
        end
        check("t5.full_q", 64'(q_count), 64'd4);
        check("t5.lu_ready", 64'(lu_ready), 64'd0);
        set_lu(1'b1, 5'd20, 32'h120);
        for (int i = 0; i < 4; i++) step();
        check("t5.stall_pre", 64'(stall_req), 64'd0);
        step();
        check("t5.stall", 64'(stall_req), 64'd1);
        check("t5.no_push_full", 64'(q_count), 64'd4);
        check_wr("t5.pipe_wr", 1'b1, 5'd1, 32'h1);
        set_pipe(1'b0, '0, '0);
        set_lu(1'b0, '0, '0);
        for (int i = 0; i < 4; i++) begin
            step();
            check_wr($sformatf("t5.drain%0d", i), 1'b1, 5'(10 + i), 32'(32'h100 + 10 + i));
            if (i == 0) check("t5.stall_clr", 64'(stall_req), 64'd0);
        end
        check("t5.q_empty", 64'(q_count), 64'd0);

        // r0 writes from both sources are dropped
        set_pipe(1'b1, 5'd0, 32'h5);
        set_lu(1'b1, 5'd0, 32'h6);
        step();
        set_pipe(1'b0, '0, '0);
        set_lu(1'b0, '0, '0);
        check_wr("t6.r0", 1'b0, '0, '0);
        check("t6.q_count", 64'(q_count), 64'd0);

        // pipe write to r0 does not block the queue head
        set_lu(1'b1, 5'd9, 32'h99);
        step();
        set_lu(1'b0, '0, '0);
        set_pipe(1'b1, 5'd0, 32'h55);
        step();
        set_pipe(1'b0, '0, '0);
        check_wr("t7.r0_noblock", 1'b1, 5'd9, 32'h99);

        // Asynchronous reset with three entries queued
        set_pipe(1'b1, 5'd1, 32'h1);
        for (int i = 0; i < 3; i++) begin
            set_lu(1'b1, 5'(2 + i), 32'(32'h200 + i));
            step();
        end
        set_lu(1'b0, '0, '0);
        check("t8.q_pre", 64'(q_count), 64'd3);
        set_pipe(1'b0, '0, '0);
        rst_n = 1'b0;
        #1;
        check("t8.rst_we3", 64'(we3), 64'd0);
        check("t8.rst_a3", 64'(a3), 64'd0);
        check("t8.rst_wd3", 64'(wd3), 64'd0);
        check("t8.rst_q", 64'(q_count), 64'd0);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_wr($sformatf("t8.after%0d", i), 1'b0, '0, '0);
        end
        check("t8.q_after", 64'(q_count), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
